pipe_scroller: RTL and testbench

- Downstream consumer of the pipe-column generator. Takes one 8-row column pattern per scroll tick and shifts it in at the right edge of a ROWS x COLS green-LED frame buffer; existing columns move one place left.
- Checks the bird's one-hot row against the column at BIRD_COL, raises gameOver on overlap, and counts pipes passed.
- Drives the green LED array and feeds gameOver back to the pipe generator and the game controller.

---
 rtl/pipe_scroller_if.sv | 34 +++
 rtl/pipe_scroller.sv | 128 ++++++++++++
 tb/tb_pipe_scroller.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_scroller_if.sv
// pipe_scroller_if
//   Bundles the game-side signals of pipe_scroller.
//   master : game controller / pipe generator side (drives ongoing, col_in, bird_row)
//   slave  : pipe_scroller side (drives grid, scroll_tick, gameOver, score)
//   Signals:
//     ongoing     - game-running request
//     col_in      - next column pattern, 1 = pipe pixel lit
//     bird_row    - one-hot bird row mask, all-zero = no bird
//     grid        - frame buffer, bits [c*ROWS +: ROWS] = column c
//     scroll_tick - one-cycle pulse in the cycle a shift occurs
//     gameOver    - registered collision/end flag
//     score       - pipes passed, saturating at 255
interface pipe_scroller_if #(
    parameter int ROWS = 8,
    parameter int COLS = 16
);
    logic                   ongoing;
    logic [ROWS-1:0]        col_in;
    logic [ROWS-1:0]        bird_row;
    logic [ROWS*COLS-1:0]   grid;
    logic                   scroll_tick;
    logic                   gameOver;
    logic [7:0]             score;

    modport master (
        output ongoing, col_in, bird_row,
        input  grid, scroll_tick, gameOver, score
    );

    modport slave (
        input  ongoing, col_in, bird_row,
        output grid, scroll_tick, gameOver, score
    );
endinterface

// File: rtl/pipe_scroller.sv
// pipe_scroller
//   Scrolls pipe columns through a ROWS x COLS frame buffer, checks the bird
//   against the column at BIRD_COL, flags game over and counts pipes passed.
//   Ports:
//     clk   - system clock
//     reset - synchronous, active-high
//     bus   - pipe_scroller_if.slave (ongoing, col_in, bird_row in;
//             grid, scroll_tick, gameOver, score out)
//   Optional feature: define SCROLL_SPEEDUP_EN to shorten the scroll period
//   as the score rises (TICK_DIV >> min(score[7:3], 3)).
module pipe_scroller #(
    parameter int ROWS     = 8,
    parameter int COLS     = 16,
    parameter int BIRD_COL = 2,
    parameter int TICK_DIV = 512
) (
    input  logic             clk,
    input  logic             reset,
    pipe_scroller_if.slave   bus
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ROWS*COLS-1:0]   grid_q, grid_d;
    logic [7:0]             score_q, score_d;
    logic                   gameover_q, gameover_d;

    logic [CNT_W-1:0]       last_cnt;
    logic [ROWS-1:0]        bird_col;
    logic                   collide;
    logic                   shift;

`ifdef SCROLL_SPEEDUP_EN
    // Divisor follows the registered score; the score only moves at a wrap,
    // so the new period starts with the count that follows that wrap.
    logic [1:0] spd;
    int         div;
    always_comb begin
        spd = (score_q[7:3] > 5'd3) ? 2'd3 : score_q[4:3];
        div = TICK_DIV >> spd;
        if (div < 1) begin
            div = 1;
        end
        last_cnt = CNT_W'(div - 1);
    end
`else
    assign last_cnt = CNT_W'(TICK_DIV - 1);
`endif

    always_comb begin
        bird_col = grid_q[BIRD_COL*ROWS +: ROWS];
        collide  = (state_q == RUN) && (|(bird_col & bus.bird_row));
        // >= so a shrinking divisor wraps immediately rather than overrunning
        shift    = (state_q == RUN) && !collide && bus.ongoing && (cnt_q >= last_cnt);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grid_d     = grid_q;
        score_d    = score_q;
        gameover_d = gameover_q;
        unique case (state_q)
            IDLE: begin
                grid_d = '0;
                cnt_d  = '0;
                if (bus.ongoing) begin
                    state_d = RUN;
                    score_d = '0;
                end
            end
            RUN: begin
                // Collision outranks both a stop request and a pending shift.
                if (collide) begin
                    state_d    = OVER;
                    gameover_d = 1'b1;
                end else if (!bus.ongoing) begin
                    state_d = IDLE;
                    grid_d  = '0;
                    cnt_d   = '0;
                end else if (shift) begin
                    grid_d = {bus.col_in, grid_q[ROWS*COLS-1:ROWS]};
                    cnt_d  = '0;
                    if ((|bird_col) && (score_q != 8'hFF)) begin
                        score_d = score_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OVER: begin
                if (!bus.ongoing) begin
                    state_d    = IDLE;
                    gameover_d = 1'b0;
                    grid_d     = '0;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grid_q     <= '0;
            score_q    <= '0;
            gameover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grid_q     <= grid_d;
            score_q    <= score_d;
            gameover_q <= gameover_d;
        end
    end

    assign bus.grid        = grid_q;
    assign bus.scroll_tick = shift;
    assign bus.gameOver    = gameover_q;
    assign bus.score       = score_q;
endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller
//   Scoreboard bench for pipe_scroller. The driver applies inputs on the
//   falling edge, asks a column-queue reference model what the DUT should
//   show this cycle, queues that expectation and advances the model across
//   the coming rising edge. A separate monitor pops and compares each cycle.
module tb_pipe_scroller;
    localparam int ROWS = 8;
    localparam int COLS = 16;
    localparam int BIRD = 2;
`ifdef SCROLL_SPEEDUP_EN
    localparam int TD = 16;
`else
    localparam int TD = 4;
`endif
    localparam int GW = ROWS * COLS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_scroller_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    pipe_scroller #(
        .ROWS(ROWS),
        .COLS(COLS),
        .BIRD_COL(BIRD),
        .TICK_DIV(TD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        bit          chk;
        bit          tick;
        logic [GW-1:0] grid;
        int          score;
        bit          go;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 0;

    // Reference model: the frame buffer is a queue of columns, leftmost first.
    typedef enum {S_IDLE, S_RUN, S_OVER} mst_t;
    mst_t       m_st    = S_IDLE;
    bit         m_known = 0;
    logic [7:0] m_cols[$];
    int         m_cnt   = 0;   // cycles spent in RUN since the last shift
    int         m_score = 0;
    int         m_ticks = 0;
    bit         m_go    = 0;

    function automatic int period(input int s);
`ifdef SCROLL_SPEEDUP_EN
        int sh;
        int p;
        sh = s / 8;
        if (sh > 3) sh = 3;
        p = TD >> sh;
        return (p < 1) ? 1 : p;
`else
        return TD + 0 * s;
`endif
    endfunction

    function automatic logic [GW-1:0] flat();
        logic [GW-1:0] g;
        g = '0;
        for (int i = 0; i < COLS; i++) g[i*ROWS +: ROWS] = m_cols[i];
        return g;
    endfunction

    task automatic clear_cols();
        for (int i = 0; i < COLS; i++) m_cols[i] = 8'h00;
        m_cnt = 0;
    endtask

    task automatic model_step(input bit r, input bit o, input logic [7:0] c, input logic [7:0] b);
        exp_t e;
        bit   coll;
        bit   tk;
        coll    = (m_st == S_RUN) && ((m_cols[BIRD] & b) != 8'h00);
        tk      = (m_st == S_RUN) && !coll && o && (m_cnt == period(m_score) - 1);
        e.chk   = m_known;
        e.tick  = tk;
        e.grid  = flat();
        e.score = m_score;
        e.go    = m_go;
        sb.push_back(e);
        if (r) begin
            m_known = 1;
            m_st    = S_IDLE;
            m_score = 0;
            m_go    = 0;
            clear_cols();
        end else begin
            case (m_st)
                S_IDLE: begin
                    clear_cols();
                    if (o) begin
                        m_st    = S_RUN;
                        m_score = 0;
                    end
                end
                S_RUN: begin
                    if (coll) begin
                        m_st = S_OVER;
                        m_go = 1;
                    end else if (!o) begin
                        m_st = S_IDLE;
                        clear_cols();
                    end else if (tk) begin
                        if (m_cols[BIRD] != 8'h00 && m_score < 255) m_score++;
                        void'(m_cols.pop_front());
                        m_cols.push_back(c);
                        m_cnt = 0;
                        m_ticks++;
                    end else begin
                        m_cnt++;
                    end
                end
                default: begin
                    if (!o) begin
                        m_st = S_IDLE;
                        m_go = 0;
                        clear_cols();
                    end
                end
            endcase
        end
    endtask

    task automatic step(input bit r, input bit o, input logic [7:0] c, input logic [7:0] b);
        @(negedge clk);
        reset        = r;
        bus.ongoing  = o;
        bus.col_in   = c;
        bus.bird_row = b;
        model_step(r, o, c, b);
    endtask

    task automatic check(input string name, input logic [GW-1:0] got, input logic [GW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name, input int guard, input int limit);
        n_tests++;
        if (guard >= limit) begin
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, expected fewer than %0d", name, guard, limit);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                if (!done) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got no expectation at t=%0t, expected one", $time);
                end
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    n_tests++;
                    if (bus.scroll_tick !== e.tick || bus.grid !== e.grid ||
                        bus.score !== 8'(e.score) || bus.gameOver !== e.go) begin
                        n_fail++;
                        $display("FAIL cycle t=%0t: got tick=%b score=%0d gameOver=%b grid=%h, expected tick=%b score=%0d gameOver=%b grid=%h",
                                 $time, bus.scroll_tick, bus.score, bus.gameOver, bus.grid,
                                 e.tick, e.score, e.go, e.grid);
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        int         guard;
        int         sc;
        bit         r;
        bit         o;
        logic [7:0] c;
        logic [7:0] b;
        logic [GW-1:0] cmp;

        reset        = 1'b1;
        bus.ongoing  = 1'b0;
        bus.col_in   = 8'h00;
        bus.bird_row = 8'h00;
        for (int i = 0; i < COLS; i++) m_cols.push_back(8'h00);

        // Scroll: constant pipe, no bird
        step(1, 0, 8'h00, 8'h00);
        step(1, 0, 8'h00, 8'h00);
        check("reset_grid", bus.grid, '0);
        check("reset_score", GW'(bus.score), '0);
        m_ticks = 0;
        guard   = 0;
        while (m_ticks < 14 && guard < 40 * TD) begin
            step(0, 1, 8'hC7, 8'h00);
            guard++;
        end
        timeout("scroll_wait", guard, 40 * TD);
        step(0, 1, 8'hC7, 8'h00);
        cmp = '0;
        for (int i = BIRD; i < COLS; i++) cmp[i*ROWS +: ROWS] = 8'hC7;
        check("scroll_cols", bus.grid, cmp);
        check("scroll_gameover", GW'(bus.gameOver), '0);

        // Collision: single pipe hits a bird in row 0
        step(1, 0, 8'h00, 8'h00);
        step(1, 0, 8'h00, 8'h00);
        m_ticks = 0;
        guard   = 0;
        while (!m_go && guard < 40 * TD) begin
            step(0, 1, (m_ticks == 0) ? 8'hC7 : 8'h00, 8'h01);
            guard++;
        end
        timeout("collision_wait", guard, 40 * TD);
        step(0, 1, 8'h00, 8'h01);
        check("collision_gameover", GW'(bus.gameOver), GW'(1));
        cmp = bus.grid;
        for (int i = 0; i < 20; i++) step(0, 1, $urandom, 8'h01);
        check("over_grid_frozen", bus.grid, cmp);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 8'h00);
        check("over_exit_grid", bus.grid, '0);
        check("over_exit_gameover", GW'(bus.gameOver), '0);

        // Score: alternating pipes with the bird in the gap row
        step(1, 0, 8'h00, 8'h00);
        guard   = 0;
        m_ticks = 0;
        while (m_score < 5 && guard < 80 * TD) begin
            step(0, 1, (m_ticks % 2 == 0) ? 8'h8F : 8'h00, 8'h10);
            guard++;
        end
        timeout("score_wait", guard, 80 * TD);
        step(0, 1, 8'h00, 8'h10);
        check("score_five", GW'(bus.score), GW'(5));
        check("score_gameover", GW'(bus.gameOver), '0);

        // Collision in the same cycle as a due shift
        step(1, 0, 8'h00, 8'h00);
        guard   = 0;
        m_ticks = 0;
        while (!(m_ticks >= 14 && m_cnt == period(m_score) - 1) && guard < 40 * TD) begin
            step(0, 1, 8'hFF, 8'h00);
            guard++;
        end
        timeout("simul_wait", guard, 40 * TD);
        sc  = m_score;
        cmp = bus.grid;
        step(0, 1, 8'h5A, 8'h01);
        step(0, 1, 8'h5A, 8'h01);
        check("simul_gameover", GW'(bus.gameOver), GW'(1));
        check("simul_score", GW'(bus.score), GW'(sc));
        check("simul_no_shift", bus.grid, cmp);

        // Reset mid-game
        step(1, 0, 8'h00, 8'h00);
        guard   = 0;
        m_ticks = 0;
        while (m_score < 3 && guard < 80 * TD) begin
            step(0, 1, (m_ticks % 2 == 0) ? 8'h8F : 8'h00, 8'h10);
            guard++;
        end
        timeout("midreset_wait", guard, 80 * TD);
        step(1, 1, 8'h8F, 8'h10);
        step(0, 1, 8'h8F, 8'h10);
        check("midreset_grid", bus.grid, '0);
        check("midreset_score", GW'(bus.score), '0);
        check("midreset_gameover", GW'(bus.gameOver), '0);
        for (int i = 0; i < 3 * TD; i++) step(0, 1, 8'h81, 8'h10);

`ifdef SCROLL_SPEEDUP_EN
        // Speed-up: score climbs past 40 with a solid wall and no bird
        step(1, 0, 8'h00, 8'h00);
        guard = 0;
        while (m_score < 41 && guard < 2000) begin
            step(0, 1, 8'hFF, 8'h00);
            guard++;
        end
        timeout("speedup_wait", guard, 2000);
        for (int i = 0; i < 20; i++) step(0, 1, 8'hFF, 8'h00);
`endif

        // Randomised play
        step(1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 149) == 0);
            o = ($urandom_range(0, 24) != 0);
            c = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 8'h00;
                1, 2:    b = 8'h01 << $urandom_range(0, 7);
                default: b = 8'($urandom);
            endcase
            step(r, o, c, b);
        end

        done = 1;
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
